// File: rtl/lm_sm_sequencer_if.sv
// Decode-stage bus between the pipeline and the LM/SM sequencer.
// The pipeline side uses master and the sequencer uses slave.
interface lm_sm_sequencer_if;
  logic [15:0] id_IR;
  logic        id_valid;
  logic        hold;
  logic        flush;
  logic        modify_ir;
  logic [2:0]  modify_pr2_ra;
  logic        first_multiple;
  logic        stall_fetch;
  logic        busy;
  logic [3:0]  xfer_cnt;

  modport master (
    output id_IR, id_valid, hold, flush,
    input  modify_ir, modify_pr2_ra, first_multiple, stall_fetch, busy, xfer_cnt
  );

  modport slave (
    input  id_IR, id_valid, hold, flush,
    output modify_ir, modify_pr2_ra, first_multiple, stall_fetch, busy, xfer_cnt
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Splits LM/SM instructions into one register transfer per cycle, lowest
// register first, by rewriting IR[11:9] and stalling fetch until the list is done.
module lm_sm_sequencer (
  input logic              clk,
  input logic              reset,
  lm_sm_sequencer_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [7:0]  mask_q, mask_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        is_lmsm;
  logic [7:0]  src;
  logic [7:0]  rest;
  logic [2:0]  idx;
  logic        multi;
  logic        mod_ir;
  logic        first_m;
  logic        stall;

  logic unused_ir_bits;
  assign unused_ir_bits = ^bus.id_IR[11:8];

  assign is_lmsm = bus.id_valid && (bus.id_IR[15:13] == 3'b011);

  always_comb begin
    // In BUSY the list comes only from the stored mask; id_IR is ignored.
    src = '0;
    if (state_q == BUSY) begin
      src = mask_q;
    end else if (is_lmsm) begin
      src = bus.id_IR[7:0];
    end
    idx = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (src[i-1]) idx = 3'(i - 1);
    end
    rest  = src & (src - 8'd1);
    multi = (rest != '0);
  end

  always_comb begin
    mod_ir  = 1'b0;
    first_m = 1'b0;
    stall   = 1'b0;
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = IDLE;
      mask_d  = '0;
      cnt_d   = '0;
    end else begin
      if (src != '0) begin
        mod_ir  = 1'b1;
        first_m = (state_q == IDLE);
        stall   = multi;
      end
      if (bus.hold && state_q == BUSY) stall = 1'b1;
      if (!bus.hold) begin
        unique case (state_q)
          IDLE: begin
            if (multi) begin
              state_d = BUSY;
              mask_d  = rest;
              cnt_d   = 4'd1;
            end
          end
          BUSY: begin
            if (multi) begin
              mask_d = rest;
              cnt_d  = cnt_q + 4'd1;
            end else begin
              state_d = IDLE;
              mask_d  = '0;
              cnt_d   = '0;
            end
          end
          default: begin
            state_d = IDLE;
            mask_d  = '0;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.modify_ir      = mod_ir;
  assign bus.modify_pr2_ra  = mod_ir ? idx : 3'd0;
  assign bus.first_multiple = first_m;
  assign bus.stall_fetch    = stall;
  assign bus.busy           = (state_q == BUSY);
  assign bus.xfer_cnt       = cnt_q;
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: directed scenarios plus a random
// run compared against a queue-based model of the transfer list.
module tb_lm_sm_sequencer;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  lm_sm_sequencer_if bus ();

  lm_sm_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [15:0] NOP = 16'hF000;

  // {modify_ir, ra, first_multiple, stall_fetch, busy, xfer_cnt}
  function automatic logic [10:0] pk(bit m, int ra, bit fm, bit st, bit b, int c);
    return {m, 3'(ra), fm, st, b, 4'(c)};
  endfunction

  function automatic logic [10:0] obs();
    return {bus.modify_ir, bus.modify_pr2_ra, bus.first_multiple,
            bus.stall_fetch, bus.busy, bus.xfer_cnt};
  endfunction

  task automatic apply(input logic [15:0] ir, input logic v, input logic h, input logic f);
    @(negedge clk);
    bus.id_IR    = ir;
    bus.id_valid = v;
    bus.hold     = h;
    bus.flush    = f;
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    reset = 1'b0;
    apply(NOP, 1'b1, 1'b0, 1'b0);
    e = pk(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_state: got %h exp %h", obs(), e);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_lm_multi();
    int ra[4] = '{0, 2, 5, 7};
    logic [10:0] e;
    for (int k = 0; k < 5; k++) begin
      apply((k < 4) ? 16'h60A5 : NOP, 1'b1, 1'b0, 1'b0);
      e = (k < 4) ? pk(1, ra[k], k == 0, k < 3, k > 0, k) : pk(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL lm_a5 cyc %0d: got %h exp %h", k, obs(), e);
      end
    end
  endtask

  task automatic test_sm_single();
    logic [10:0] e;
    for (int k = 0; k < 2; k++) begin
      apply((k == 0) ? 16'h7010 : NOP, 1'b1, 1'b0, 1'b0);
      e = (k == 0) ? pk(1, 4, 1, 0, 0, 0) : pk(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL sm_single cyc %0d: got %h exp %h", k, obs(), e);
      end
    end
  endtask

  task automatic test_hold();
    int hl[11] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    int ra[11] = '{0, 1, 1, 1, 1, 2, 3, 4, 5, 6, 7};
    logic [10:0] e;
    for (int k = 0; k < 12; k++) begin
      apply((k < 11) ? 16'h60FF : NOP, 1'b1, (k < 11) ? 1'(hl[k]) : 1'b0, 1'b0);
      e = (k < 11) ? pk(1, ra[k], k == 0, k < 10, k > 0, ra[k]) : pk(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL hold_ff cyc %0d: got %h exp %h", k, obs(), e);
      end
    end
  endtask

  task automatic test_flush();
    logic [10:0] e;
    for (int k = 0; k < 3; k++) begin
      apply((k < 2) ? 16'h60F0 : NOP, 1'b1, 1'b0, k == 1);
      e = (k == 0) ? pk(1, 4, 1, 1, 0, 0) : (k == 1) ? pk(0, 0, 0, 0, 1, 1) : pk(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL flush_f0 cyc %0d: got %h exp %h", k, obs(), e);
      end
    end
  endtask

  task automatic test_nop();
    logic [15:0] irs[5] = '{16'h6000, 16'h7000, 16'hF000, 16'h60FF, 16'h5EFF};
    for (int k = 0; k < 5; k++) begin
      apply(irs[k], k != 3, 1'b0, 1'b0);
      checks++;
      if (obs() !== 11'd0) begin
        errors++;
        $display("FAIL nop cyc %0d ir %h: got %h exp 000", k, irs[k], obs());
      end
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] e;
    for (int k = 0; k < 3; k++) apply(16'h60FF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    e = pk(1, 0, 1, 1, 0, 0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL async_reset: got %h exp %h", obs(), e);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_restart: got %h exp %h", obs(), e);
    end
    apply(NOP, 1'b1, 1'b0, 1'b1);
    apply(NOP, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs() !== 11'd0) begin
      errors++;
      $display("FAIL post_reset_flush: got %h exp 000", obs());
    end
  endtask

  task automatic test_random();
    int q[$];
    int lst[$];
    int mcnt;
    logic [15:0] ir;
    logic v, h, f;
    logic [10:0] e;
    @(negedge clk);
    reset = 1'b0;
    #1 reset = 1'b1;
    q.delete();
    mcnt = 0;
    for (int n = 0; n < 500; n++) begin
      ir = 16'($urandom);
      case ($urandom_range(0, 3))
        0, 2:    ir[15:12] = 4'h6;
        1:       ir[15:12] = 4'h7;
        default: ir[15:12] = 4'($urandom_range(8, 15));
      endcase
      if ($urandom_range(0, 3) == 0) ir[7:0] = 8'(1 << $urandom_range(0, 7));
      v = ($urandom_range(0, 9) != 0);
      h = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 12) == 0);
      lst.delete();
      if (v && (ir[15:12] == 4'h6 || ir[15:12] == 4'h7))
        for (int i = 0; i < 8; i++) if (ir[i]) lst.push_back(i);
      e = pk(0, 0, 0, 0, q.size() != 0, mcnt);
      if (!f) begin
        if (q.size() != 0) e = pk(1, q[0], 0, (q.size() > 1) || h, 1, mcnt);
        else if (lst.size() != 0) e = pk(1, lst[0], 1, lst.size() > 1, 0, mcnt);
      end
      apply(ir, v, h, f);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL random cyc %0d ir %h v%0b h%0b f%0b: got %h exp %h", n, ir, v, h, f, obs(), e);
      end
      if (f) begin
        q.delete();
        mcnt = 0;
      end else if (!h) begin
        if (q.size() != 0) begin
          void'(q.pop_front());
          mcnt = (q.size() == 0) ? 0 : mcnt + 1;
        end else if (lst.size() > 1) begin
          q = lst;
          void'(q.pop_front());
          mcnt = 1;
        end
      end
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b0;
    bus.id_IR    = NOP;
    bus.id_valid = 1'b0;
    bus.hold     = 1'b0;
    bus.flush    = 1'b0;
    test_reset();
    test_lm_multi();
    test_sm_single();
    test_hold();
    test_flush();
    test_nop();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lm_sm_sequencer.md
LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port: id_IR  input  16  instruction currently held in the decode-stage pipeline register.
REQ-004 SHALL have port: id_valid  input  1  id_IR holds a real instruction (0 = bubble).
REQ-005 SHALL have port: hold  input  1  downstream stall; sequencer freezes state and outputs.
REQ-006 SHALL have port: flush  input  1  branch/jump redirect; abort any sequence.
REQ-007 SHALL have port: modify_ir  output  1  substitute IR[11:9] in the decode-to-execute register.
REQ-008 SHALL have port: modify_pr2_ra  output  3  register index substituted into IR[11:9].
REQ-009 SHALL have port: first_multiple  output  1  current transfer is the first of its LM/SM (base address, no increment).
REQ-010 SHALL have port: stall_fetch  output  1  hold PC and fetch-to-decode register; re-present same id_IR.
REQ-011 SHALL have port: busy  output  1  sequence in progress (state BUSY).
REQ-012 SHALL have port: xfer_cnt  output  4  transfers issued in current sequence, 0..8.

Function
REQ-013 SHALL decode LM as id_IR[15:12]=4'b0110, SM as 4'b0111; register list = id_IR[7:0], bit i selects Ri.
REQ-014 SHALL have two states, IDLE and BUSY, plus registers mask[7:0] (remaining list) and xfer_cnt.
REQ-015 SHALL generate modify_ir, modify_pr2_ra, first_multiple and stall_fetch combinationally from state, mask, id_IR and flush (zero-cycle latency).
REQ-016 IDLE, no LM/SM or id_valid=0: all outputs 0, stay IDLE.
REQ-017 IDLE, LM/SM, id_valid=1, list=0: outputs 0, stay IDLE; instruction passes unmodified (architectural NOP).
REQ-018 IDLE, LM/SM, id_valid=1, list!=0: modify_ir=1, modify_pr2_ra=index of lowest set bit, first_multiple=1.
REQ-019 In REQ-018, if exactly one bit set: stall_fetch=0, stay IDLE, xfer_cnt unchanged at 0; otherwise stall_fetch=1, next state BUSY, mask=list with lowest set bit cleared, xfer_cnt=1.
REQ-020 BUSY: modify_ir=1, modify_pr2_ra=lowest set bit of mask, first_multiple=0.
REQ-021 BUSY: if mask has more than one bit set, stall_fetch=1, clear lowest bit, xfer_cnt+1, stay BUSY.
REQ-022 BUSY: if mask has one bit set, stall_fetch=0, mask=0, xfer_cnt=0, next state IDLE.
REQ-023 Priority encoding SHALL be lowest index first (R0 before R7); max sequence 8 transfers, xfer_cnt never exceeds 7 while BUSY.
REQ-024 hold=1 SHALL freeze state, mask and xfer_cnt; outputs keep their current combinational values; stall_fetch SHALL be forced 1 while hold=1 and busy=1.
REQ-025 flush=1 SHALL force all combinational outputs to 0 in that cycle and next state IDLE, mask=0, xfer_cnt=0; flush has priority over hold.
REQ-026 busy SHALL equal (state==BUSY); in BUSY, id_IR is not re-decoded (list comes from mask only).

Reset
REQ-027 reset=0 SHALL asynchronously set state=IDLE, mask=0, xfer_cnt=0; busy=0 and, with no LM/SM present, all other outputs 0.
REQ-028 Reset asserted mid-sequence SHALL abort it immediately; after release, the sequencer restarts from IDLE on the current id_IR.

Verification
REQ-029 LM list 8'b1010_0101 -> modify_pr2_ra 0,2,5,7 on 4 consecutive cycles; first_multiple 1,0,0,0; stall_fetch 1,1,1,0; busy 0,1,1,1.
REQ-030 SM list 8'b0001_0000 -> single cycle: modify_pr2_ra=4, first_multiple=1, stall_fetch=0, busy stays 0.
REQ-031 LM list 8'hFF with hold=1 on 2nd cycle for 3 cycles -> modify_pr2_ra sequence 0,1,1,1,1,2..7; total 11 cycles; stall_fetch 1 until R7 cycle.
REQ-032 LM list 8'hF0, flush=1 on 2nd cycle -> that cycle outputs 0; next cycle busy=0, xfer_cnt=0.
REQ-033 LM list 8'h00 and non-LM/SM id_IR (e.g. 16'hF000) -> all outputs 0 every cycle.
REQ-034 reset=0 asynchronously during BUSY of list 8'hFF -> busy=0, xfer_cnt=0 before next clock edge.
